// File: rtl/i2c_slave_burst_if.sv
// i2c_slave_burst_if: pin-side and register-file-side signals of the I2C target.
interface i2c_slave_burst_if #(parameter int REG_AW = 8);
   logic scl_in, sda_in, sda_oe, reg_wen, reg_ren, busy;
   logic [REG_AW-1:0] reg_addr;
   logic [7:0] reg_wdata, reg_rdata;
   modport slave(input scl_in, sda_in, reg_rdata, output sda_oe, reg_wen, reg_ren, reg_addr, reg_wdata, busy);
   modport master(output scl_in, sda_in, reg_rdata, input sda_oe, reg_wen, reg_ren, reg_addr, reg_wdata, busy);
endinterface

// File: rtl/i2c_slave_burst.sv
// i2c_slave_burst: I2C target with 1/2-byte register pointer and burst access.
// Define I2C_AUTO_INC_EN to advance the pointer after every data byte.
module i2c_slave_burst #(
   parameter logic [6:0] SLAVE_ADDR = 7'h50,
   parameter int REG_AW = 8,
   parameter int SYNC_STAGES = 2
) (
   input logic sys_clk,
   input logic reset,
   i2c_slave_burst_if.slave bus
);
   typedef enum logic [3:0] {IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK, RD_LOAD, RD_DATA, RD_ACK} state_t;
   state_t state, state_n;
   logic [SYNC_STAGES-1:0] scl_sy, sda_sy;
   logic scl_s, sda_s, scl_q, sda_q, scl_rise, scl_fall, start, stop;
   logic [7:0] shift, byte_in, wdata;
   logic [2:0] cnt;
   logic [REG_AW-1:0] ptr;
   logic [REG_AW+7:0] ptr_cat;
   logic ab, ren_q, oe, wen, busy, last_bit, ack_done, inc;
   assign scl_s = scl_sy[SYNC_STAGES-1];
   assign sda_s = sda_sy[SYNC_STAGES-1];
   assign scl_rise = scl_s & ~scl_q;
   assign scl_fall = ~scl_s & scl_q;
   assign start = scl_s & scl_q & sda_q & ~sda_s;
   assign stop = scl_s & scl_q & ~sda_q & sda_s;
   assign byte_in = {shift[6:0], sda_s};
   assign ptr_cat = {ptr, byte_in};
   assign last_bit = scl_rise && cnt == 3'd7;
   // ACK states drive on the first SCL fall and finish on the second
   assign ack_done = scl_fall && oe;
`ifdef I2C_AUTO_INC_EN
   assign inc = (state == WR_ACK && ack_done) || (state == RD_ACK && scl_rise && !sda_s);
`else
   assign inc = 1'b0;
`endif
   assign bus.sda_oe = oe;
   assign bus.reg_wen = wen;
   assign bus.reg_ren = state == RD_LOAD;
   assign bus.reg_addr = ptr;
   assign bus.reg_wdata = wdata;
   assign bus.busy = busy;
   always_comb begin
      state_n = state;
      if (start) state_n = DEV_ADDR;
      else if (stop) state_n = IDLE;
      else
         case (state)
            DEV_ADDR: if (last_bit) state_n = byte_in[7:1] == SLAVE_ADDR ? DEV_ACK : IDLE;
            DEV_ACK: if (ack_done) state_n = shift[0] ? RD_LOAD : REG_ADDR;
            REG_ADDR: if (last_bit) state_n = REG_ACK;
            REG_ACK: if (ack_done) state_n = (REG_AW == 16 && !ab) ? REG_ADDR : WR_DATA;
            WR_DATA: if (last_bit) state_n = WR_ACK;
            WR_ACK: if (ack_done) state_n = WR_DATA;
            RD_LOAD: state_n = RD_DATA;
            RD_DATA: if (last_bit) state_n = RD_ACK;
            RD_ACK: if (scl_rise) state_n = sda_s ? IDLE : RD_LOAD;
            default: state_n = state;
         endcase
   end
   always_ff @(posedge sys_clk or posedge reset)
      if (reset) begin
         scl_sy <= '1;
         sda_sy <= '1;
         scl_q <= 1'b1;
         sda_q <= 1'b1;
      end else begin
         scl_sy <= {scl_sy[SYNC_STAGES-2:0], bus.scl_in};
         sda_sy <= {sda_sy[SYNC_STAGES-2:0], bus.sda_in};
         scl_q <= scl_s;
         sda_q <= sda_s;
      end
   always_ff @(posedge sys_clk or posedge reset)
      if (reset) begin
         state <= IDLE;
         shift <= '0;
         cnt <= '0;
         ptr <= '0;
         wdata <= '0;
         ab <= 1'b0;
         ren_q <= 1'b0;
         oe <= 1'b0;
         wen <= 1'b0;
         busy <= 1'b0;
      end else begin
         state <= state_n;
         ren_q <= state == RD_LOAD;
         wen <= last_bit && state == WR_DATA;
         busy <= state_n == IDLE ? 1'b0 : (state == DEV_ADDR && state_n == DEV_ACK) ? 1'b1 : busy;
         if (start) begin
            cnt <= '0;
            oe <= 1'b0;
         end else if (stop) oe <= 1'b0;
         else begin
            if (scl_rise && state inside {DEV_ADDR, REG_ADDR, WR_DATA, RD_DATA}) begin
               shift <= byte_in;
               cnt <= cnt + 3'd1;
            end
            if (last_bit && state == REG_ADDR) ptr <= ptr_cat[REG_AW-1:0];
            if (last_bit && state == WR_DATA) wdata <= byte_in;
            if (inc) ptr <= ptr + 1'b1;
            if (state == DEV_ACK) ab <= 1'b0;
            else if (state == REG_ACK && ack_done) ab <= 1'b1;
            // first read byte arrives while SCL is low and is driven at once; later ones wait for the fall
            if (scl_fall && state inside {DEV_ACK, REG_ACK, WR_ACK}) oe <= ~oe;
            else if (scl_fall && state == RD_DATA) oe <= ~shift[7];
            else if (scl_fall && state == RD_ACK) oe <= 1'b0;
            else if (ren_q) begin
               shift <= bus.reg_rdata;
               oe <= ~scl_s & ~bus.reg_rdata[7];
            end
         end
      end
endmodule

// File: tb/tb_i2c_slave_burst.sv
// tb_i2c_slave_burst: bit-banged I2C master driving an 8-bit and a 16-bit pointer target on one bus,
// with register-file models and write/read strobe scoreboards.
module tb_i2c_slave_burst;
   localparam int H = 40;
`ifdef I2C_AUTO_INC_EN
   localparam int INC = 1;
`else
   localparam int INC = 0;
`endif
   typedef struct packed {logic v; logic [15:0] a; logic [7:0] d;} wr_t;
   logic sys_clk = 1'b0, reset = 1'b1, scl_m = 1'b1, sda_m = 1'b1, line;
   int n_chk = 0, n_err = 0, oe_cnt = 0;
   logic [7:0] rf0 [256];
   logic [7:0] rf1 [65536];
   logic [7:0] em0 [256];
   logic [7:0] em1 [65536];
   logic [15:0] pm [2];
   wr_t wq0[$], wq1[$];
   logic [16:0] rq0[$], rq1[$];
   logic [7:0] dq[$];

   i2c_slave_burst_if #(.REG_AW(8)) bus8();
   i2c_slave_burst_if #(.REG_AW(16)) bus16();
   i2c_slave_burst #(.SLAVE_ADDR(7'h50), .REG_AW(8), .SYNC_STAGES(2)) u8 (.sys_clk(sys_clk), .reset(reset), .bus(bus8));
   i2c_slave_burst #(.SLAVE_ADDR(7'h52), .REG_AW(16), .SYNC_STAGES(3)) u16 (.sys_clk(sys_clk), .reset(reset), .bus(bus16));

   always #5 sys_clk = ~sys_clk;
   assign line = sda_m & ~bus8.sda_oe & ~bus16.sda_oe;
   assign bus8.scl_in = scl_m;
   assign bus8.sda_in = line;
   assign bus16.scl_in = scl_m;
   assign bus16.sda_in = line;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic wr_t pop_w(input int dev);
      if (dev != 0) return wq1.size() != 0 ? wq1.pop_front() : '0;
      return wq0.size() != 0 ? wq0.pop_front() : '0;
   endfunction

   function automatic logic [16:0] pop_r(input int dev);
      if (dev != 0) return rq1.size() != 0 ? rq1.pop_front() : '0;
      return rq0.size() != 0 ? rq0.pop_front() : '0;
   endfunction

   always @(negedge sys_clk) begin
      if (bus8.sda_oe | bus16.sda_oe) oe_cnt <= oe_cnt + 1;
      if (bus8.reg_wen) begin
         rf0[bus8.reg_addr] <= bus8.reg_wdata;
         check("wen8", {7'h0, 1'b1, 8'h00, bus8.reg_addr, bus8.reg_wdata}, 32'(pop_w(0)));
      end
      if (bus16.reg_wen) begin
         rf1[bus16.reg_addr] <= bus16.reg_wdata;
         check("wen16", {7'h0, 1'b1, bus16.reg_addr, bus16.reg_wdata}, 32'(pop_w(1)));
      end
      if (bus8.reg_ren) check("ren8", {15'h0, 1'b1, 8'h00, bus8.reg_addr}, 32'(pop_r(0)));
      if (bus16.reg_ren) check("ren16", {15'h0, 1'b1, bus16.reg_addr}, 32'(pop_r(1)));
   end

   always @(posedge sys_clk) begin
      if (bus8.reg_ren) bus8.reg_rdata <= rf0[bus8.reg_addr];
      if (bus16.reg_ren) bus16.reg_rdata <= rf1[bus16.reg_addr];
   end

   function automatic logic [6:0] dev_id(input int dev);
      return dev != 0 ? 7'h52 : 7'h50;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic put_bit(input logic b);
      tick(4); sda_m = b; tick(H - 4); scl_m = 1'b1; tick(H); scl_m = 1'b0;
   endtask

   task automatic get_bit(output logic b);
      tick(4); sda_m = 1'b1; tick(H - 4); scl_m = 1'b1; tick(H / 2); b = line; tick(H / 2); scl_m = 1'b0;
   endtask

   task automatic i2c_start;
      tick(4); sda_m = 1'b1; tick(H - 4); scl_m = 1'b1; tick(H); sda_m = 1'b0; tick(H); scl_m = 1'b0;
   endtask

   task automatic i2c_stop;
      tick(4); sda_m = 1'b0; tick(H - 4); scl_m = 1'b1; tick(H); sda_m = 1'b1; tick(H);
   endtask

   task automatic send(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) put_bit(b[i]);
      get_bit(ack);
   endtask

   task automatic recv(input logic nack, output logic [7:0] b);
      logic t;
      for (int i = 7; i >= 0; i--) begin
         get_bit(t);
         b[i] = t;
      end
      put_bit(nack);
   endtask

   task automatic bump(input int dev);
      pm[dev] = (pm[dev] + 16'(INC)) & (dev != 0 ? 16'hFFFF : 16'h00FF);
   endtask

   task automatic set_ptr(input int dev, input logic [15:0] ra);
      logic ack;
      i2c_start;
      send({dev_id(dev), 1'b0}, ack);
      check("dev_ack_w", 32'(ack), 0);
      if (dev != 0) begin
         send(ra[15:8], ack);
         check("reg_ack_hi", 32'(ack), 0);
      end
      send(ra[7:0], ack);
      check("reg_ack", 32'(ack), 0);
      pm[dev] = ra;
   endtask

   task automatic wr_burst(input int dev, input logic [15:0] ra, input int n, input logic [31:0] data);
      logic ack;
      logic [7:0] d;
      set_ptr(dev, ra);
      for (int i = 0; i < n; i++) begin
         d = data[8*i +: 8];
         if (dev != 0) begin
            wq1.push_back({1'b1, pm[1], d});
            em1[pm[1]] = d;
         end else begin
            wq0.push_back({1'b1, pm[0], d});
            em0[pm[0][7:0]] = d;
         end
         send(d, ack);
         check("data_ack", 32'(ack), 0);
         bump(dev);
      end
      i2c_stop;
   endtask

   task automatic rd_burst(input int dev, input logic set, input logic [15:0] ra, input int n);
      logic ack;
      logic [7:0] got;
      if (set) set_ptr(dev, ra);
      for (int i = 0; i < n; i++) begin
         if (dev != 0) begin
            rq1.push_back({1'b1, pm[1]});
            dq.push_back(em1[pm[1]]);
         end else begin
            rq0.push_back({1'b1, pm[0]});
            dq.push_back(em0[pm[0][7:0]]);
         end
         if (i < n - 1) bump(dev);
      end
      i2c_start;
      send({dev_id(dev), 1'b1}, ack);
      check("dev_ack_r", 32'(ack), 0);
      for (int i = 0; i < n; i++) begin
         recv(i == n - 1, got);
         check("rd_data", 32'(got), 32'(dq.pop_front()));
      end
      check("busy_after_nack", 32'(dev != 0 ? bus16.busy : bus8.busy), 0);
      i2c_stop;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic ack;
      int c;
      pm[0] = '0;
      pm[1] = '0;
      tick(3);
      check("rst_oe", 32'(bus8.sda_oe), 0);
      check("rst_wen", 32'(bus8.reg_wen), 0);
      check("rst_ren", 32'(bus8.reg_ren), 0);
      check("rst_busy", 32'(bus8.busy), 0);
      check("rst_addr", 32'(bus8.reg_addr), 0);
      check("rst_wdata", 32'(bus8.reg_wdata), 0);
      reset = 1'b0;
      tick(5);
      wr_burst(0, 16'h00C1, 2, 32'h0000_AA55);
      rd_burst(0, 1'b1, 16'h00C1, 2);
      rd_burst(0, 1'b0, 16'h0000, 1);
      c = oe_cnt;
      i2c_start;
      send(8'hA2, ack);
      check("mismatch_nack", 32'(ack), 1);
      check("mismatch_busy", 32'(bus8.busy), 0);
      check("mismatch_oe", 32'(oe_cnt - c), 0);
      i2c_stop;
      wr_burst(1, 16'hFFFF, 2, 32'h0000_3CC3);
      rd_burst(1, 1'b1, 16'hFFFF, 2);
      set_ptr(0, 16'h0020);
      for (int i = 0; i < 4; i++) put_bit(i[0]);
      i2c_stop;
      tick(10);
      check("abort_oe", 32'(bus8.sda_oe), 0);
      check("abort_busy", 32'(bus8.busy), 0);
      i2c_start;
      for (int i = 7; i >= 0; i--) put_bit(i == 7 || i == 5);
      tick(10);
      check("ack_driven", 32'(bus8.sda_oe), 1);
      reset = 1'b1;
      #1;
      check("rst_async_oe", 32'(bus8.sda_oe), 0);
      check("rst_async_busy", 32'(bus8.busy), 0);
      sda_m = 1'b1;
      tick(H);
      scl_m = 1'b1;
      tick(H);
      reset = 1'b0;
      pm[0] = '0;
      pm[1] = '0;
      tick(5);
      check("rst_ptr", 32'(bus8.reg_addr), 0);
      wr_burst(0, 16'h0010, 1, 32'h0000_0033);
      rd_burst(0, 1'b1, 16'h0010, 1);
      wr_burst(0, 16'h0010, 2, 32'h0000_4433);
      rd_burst(0, 1'b1, 16'h0010, 2);
      tick(20);
      check("wq8_left", wq0.size(), 0);
      check("wq16_left", wq1.size(), 0);
      check("rq8_left", rq0.size(), 0);
      check("rq16_left", rq1.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/i2c_slave_burst.md
# i2c_slave_burst

- Parametrised I2C target (slave) with multi-byte register addressing and burst transfers.
- Sits between the board-level SCL/SDA pins and a synchronous register file. It issues single-cycle write/read strobes into that register file, which supplies read data one clock after `reg_ren`.
- Generalises the 8-bit-address/8-bit-data single-transfer slave: adds a configurable register address width (1 or 2 address bytes) and burst read/write with a pointer that persists across transactions.

## Interface

Parameters:
- `SLAVE_ADDR`, 7'h50, 7-bit device address (8-bit write form 0xA0).
- `REG_AW`, 8, register address width; legal values 8 (one address byte) or 16 (two address bytes, MSB first).
- `SYNC_STAGES`, 2, synchroniser depth on `scl_in`/`sda_in`; minimum 2.

Ports:
- `sys_clk`, in, 1, system clock; one clock, at least 100 MHz for 400 kHz SCL.
- `reset`, in, 1, asynchronous, active-high reset.
- `scl_in`, in, 1, SCL pin level (asynchronous).
- `sda_in`, in, 1, SDA pin level (asynchronous).
- `sda_oe`, out, 1, 1 = pull SDA low (open-drain); the pad drives 0 when high, Z otherwise.
- `reg_wen`, out, 1, one-cycle write strobe.
- `reg_ren`, out, 1, one-cycle read strobe.
- `reg_addr`, out, REG_AW, register pointer.
- `reg_wdata`, out, 8, write data, valid while `reg_wen`=1.
- `reg_rdata`, in, 8, read data, valid the cycle after `reg_ren`.
- `busy`, out, 1, high from a START addressed to this device until STOP or NACK.

## Operation

**Bus conditioning**
- SCL and SDA pass through `SYNC_STAGES` flops. Edge detect runs on the synchronised values.
- START: synced SDA falls while synced SCL is high. STOP: synced SDA rises while synced SCL is high.

**Bit handling**
- Bits are sampled on the detected SCL rise, MSB first, into an 8-bit shift register with a 3-bit bit counter.

**States**
- IDLE: wait for START.
- DEV_ADDR: shift 8 bits.
  - Address bits == `SLAVE_ADDR` → DEV_ACK.
  - Mismatch → IDLE; SDA is never driven.
- DEV_ACK: drive ACK.
  - R/W=0 → REG_ADDR.
  - R/W=1 → RD_LOAD.
- REG_ADDR: shift byte(s) into the pointer; each byte is followed by REG_ACK. After the last address byte → WR_DATA.
- WR_DATA: shift 8 bits, then pulse `reg_wen` with `reg_wdata` = the byte at the current pointer → WR_ACK.
- WR_ACK: drive ACK, increment the pointer → WR_DATA.
- RD_LOAD: pulse `reg_ren`, capture `reg_rdata` into the shift register the next cycle → RD_DATA.
- RD_DATA: present 8 bits → RD_ACK.
- RD_ACK: release SDA and sample the master's bit on the SCL rise.
  - ACK (0) → increment pointer → RD_LOAD.
  - NACK (1) → IDLE.

**ACK and SDA output rules**
- ACK drive: `sda_oe` asserts on the SCL fall that ends bit 8 and releases on the following SCL fall.
- Read data: `sda_oe` = ~bit, updated on each SCL fall.

**Pointer**
- Pointer increment wraps from 2^REG_AW−1 to 0.
- The pointer persists across transactions. A read with no preceding register address reads from the current pointer.

**Boundary conditions**
- START in any state (repeated start) → DEV_ADDR, `sda_oe`=0, bit counter cleared; the pointer is kept.
- STOP in any state → IDLE, `sda_oe`=0.
- A STOP in the middle of a data byte discards the partial byte; no `reg_wen` is issued.
- Reset mid-transfer: immediately IDLE, `sda_oe`=0, strobes low, pointer 0.

## Timing

Reset values:
- `sda_oe`=0, `reg_wen`=0, `reg_ren`=0, `busy`=0.
- `reg_addr`=0, `reg_wdata`=0.

Latencies:
- Pin-to-sample latency: `SYNC_STAGES`+1 sys_clk cycles after the SCL edge.
- `reg_wen`: exactly one cycle, issued one cycle after the 8th data bit is sampled. `reg_addr` and `reg_wdata` are stable during that cycle.
- `reg_ren`: one cycle, issued on DEV_ACK exit (first byte) or RD_ACK exit (subsequent bytes). Data is captured at ren+1.
- All of this completes well before the next SCL fall; the 400 kHz budget is ≥100 cycles per half-period.

## Configuration

- `I2C_AUTO_INC_EN`
  - Defined: the pointer increments after every data byte in both directions (burst mode).
  - Undefined: the pointer stays fixed for the whole transaction, so repeated writes and reads hit the same register. The rest of the FSM is unchanged.

## Test plan

- **Burst write.** START, 0xA0, reg 0xC1, data 0x55, 0xAA, STOP.
  - ACK on all 4 bytes.
  - `reg_wen` pulses twice: (0xC1, 0x55) and (0xC2, 0xAA).
- **Random read.** START, 0xA0, 0xC1, repeated START, 0xA1, master ACK then NACK.
  - `reg_ren` at addresses 0xC1 and 0xC2.
  - SDA carries 0x55 then 0xAA.
  - `busy`=0 after NACK.
- **Address mismatch.** START, 0xA2.
  - `sda_oe` stays 0 throughout.
  - No strobes.
  - State returns to IDLE.
- **Wrap and 16-bit addressing.** `REG_AW`=16: write to 0xFFFF with 2 data bytes.
  - Second `reg_wen` is at `reg_addr`=0x0000.
- **Aborted byte.** STOP after 4 bits of a data byte → no `reg_wen`, `sda_oe`=0, IDLE.
- **Reset mid-transfer.** Assert `reset` during the DEV_ACK low phase.
  - `sda_oe` drops in the same cycle (asynchronously).
  - After release, a fresh write of 0x33 to 0x10 succeeds.
  - With `I2C_AUTO_INC_EN` undefined: a 2-byte burst writes 0x10 twice.
